wb_lsu: RTL and testbench
=========================

Name: wb_lsu

Overview:
- Load/store unit sitting between the core's memory stage and the Wishbone data port; directly upstream of the tightly-coupled data memory.
- Accepts one load or store request at a time, encoded with RISC-V funct3.
- Generates byte-lane selects and lane-aligned write data, and runs a single Wishbone classic cycle.
- Extracts and sign- or zero-extends read data, then reports completion or an error to the core.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles in BUS waiting for ack before a bus error is declared; 0 disables the timeout.

Ports:
- i_clk  in  1  clock, all logic rising-edge
- i_reset_n  in  1  asynchronous active-low reset
- i_req  in  1  core request valid; accepted only when o_ready=1
- i_we  in  1  1=store, 0=load
- i_addr  in  32  byte address
- i_wdata  in  32  store data, right-justified
- i_funct3  in  3  RISC-V size/sign code
- o_ready  out  1  LSU idle, can accept i_req
- o_done  out  1  single-cycle completion pulse
- o_rdata  out  32  extended load result, valid with o_done and held until next o_done
- o_misalign  out  1  with o_done: misaligned access, no bus cycle issued
- o_err  out  1  with o_done: illegal funct3 or bus timeout
- o_wb_addr  out  32  word address {i_addr[31:2],2'b00}
- o_wb_cyc  out  1  Wishbone cycle
- o_wb_stb  out  1  Wishbone strobe
- o_wb_we  out  1  Wishbone write enable
- o_wb_sel  out  4  byte lane selects
- o_wb_wdata  out  32  lane-aligned write data
- i_wb_ack  in  1  slave ack; may be combinational from stb&cyc
- i_wb_rdata  in  32  slave read data, valid with ack

Behaviour:
- Reset (asynchronous, immediate, including mid-transaction):
  - state=IDLE; o_ready=1; o_done, o_misalign, o_err, o_wb_cyc, o_wb_stb, o_wb_we = 0
  - o_wb_sel=0; o_wb_addr, o_wb_wdata, o_rdata = 0; timeout counter = 0
- All Wishbone outputs are registered.
- States: IDLE, BUS, RESP.
- IDLE: o_ready=1. On i_req, decode the request:
  - Illegal funct3 → RESP, err=1. Illegal: loads 011, 110, 111; stores any code other than 000/001/010.
  - Misaligned → RESP, misalign=1. Misaligned: half with addr[0]=1, word with addr[1:0]≠0.
  - Otherwise → BUS. Register addr, we, sel and wdata, and set cyc=stb=1 on the same edge.
- Lane rules:
  - Byte: sel=4'b0001<<addr[1:0]; wdata = byte replicated ×4.
  - Half: sel = addr[1] ? 4'b1100 : 4'b0011; wdata = half replicated ×2.
  - Word: sel=4'b1111.
  - Loads drive the same sel; o_wb_wdata=0 on loads.
- BUS: cyc=stb=1 held stable until ack or timeout; the counter increments each BUS cycle.
  - i_wb_ack=1 → capture extracted i_wb_rdata, drop cyc/stb on the next edge, go to RESP. The slave therefore sees stb for exactly one cycle with a combinational-ack slave.
  - Counter reaches TIMEOUT_CYCLES with no ack → drop cyc/stb, err=1, go to RESP.
  - Ack on the same cycle as timeout: ack wins.
- Read extraction:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - funct3 000/001: sign-extend. 100/101: zero-extend. 010: full word.
- RESP: o_done=1 for one cycle. o_rdata updated only for successful loads; set to 0 on misalign or err.
  - Then → IDLE; o_ready=1 again in the cycle after o_done.
- i_req while o_ready=0 is ignored (not queued).
- Latency:
  - Aligned access with combinational ack: req at cycle N, stb at N+1, o_done at N+2. Next request is accepted at N+3.
  - Misaligned or illegal access: o_done at N+1, no cyc/stb ever asserted.
- Stores report o_done with o_rdata unchanged from the prior load value.

Test Plan:
- SW addr=0x0000_0010 wdata=0xDEADBEEF, ack combinational → wb_addr=0x10, sel=1111, wdata=0xDEADBEEF, stb high one cycle, o_done at N+2, o_err=0.
- SB addr=0x13 wdata=0x0000_00A5 → sel=1000, wb_wdata=0xA5A5A5A5. Then LB addr=0x13 with rdata=0xA5000000 → o_rdata=0xFFFFFFA5; LBU at the same address → 0x000000A5.
- LH addr=0x22, rdata=0x8001_1234 → sel=1100, o_rdata=0xFFFF8001; LHU → 0x00008001.
- LW addr=0x06 → no cyc/stb, o_done at N+1 with o_misalign=1, o_rdata=0. Store funct3=011 → o_err=1, no bus cycle.
- TIMEOUT_CYCLES=4, ack tied 0 → stb high exactly 4 cycles, then dropped, o_done with o_err=1. Second request is accepted afterwards.
- Assert i_reset_n=0 while in BUS → cyc/stb/o_done low immediately without a clock edge. After release, o_ready=1 and the next LW completes normally.

Source files
------------

// File: rtl/wb_lsu.sv
// -----------------------------------------------------------------------------
// wb_lsu : load/store unit between the core memory stage and a Wishbone
// classic data port.
//
// Takes one RISC-V style load/store request at a time (size/sign in funct3),
// builds byte-lane selects and lane-replicated write data, runs a single
// Wishbone classic cycle, then extracts and extends the load result.
// Misaligned or illegal requests complete without touching the bus.
//
// Ports
//   i_clk, i_reset_n      clock (rising edge), asynchronous active-low reset
//   i_req/i_we/i_addr/i_wdata/i_funct3
//                         core request, accepted when o_ready=1
//   o_ready               idle, can accept a request
//   o_done                one-cycle completion pulse
//   o_rdata               extended load result, held until the next o_done
//   o_misalign, o_err     completion status, valid with o_done
//   o_wb_*                registered Wishbone master outputs
//   i_wb_ack, i_wb_rdata  Wishbone slave response (ack may be combinational)
// -----------------------------------------------------------------------------
module wb_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_funct3,
    output logic        o_ready,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_misalign,
    output logic        o_err,
    output logic [31:0] o_wb_addr,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [3:0]  o_wb_sel,
    output logic [31:0] o_wb_wdata,
    input  logic        i_wb_ack,
    input  logic [31:0] i_wb_rdata
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_ready;
    logic             r_done;
    logic             r_misalign;
    logic             r_err;
    logic [31:0]      r_rdata;
    logic [31:0]      r_wb_addr;
    logic             r_wb_cyc;
    logic             r_wb_stb;
    logic             r_wb_we;
    logic [3:0]       r_wb_sel;
    logic [31:0]      r_wb_wdata;
    logic [2:0]       r_funct3;
    logic [1:0]       r_off;
    logic [CNT_W-1:0] r_cnt;

    logic             w_illegal;
    logic             w_misalign;
    logic [3:0]       w_sel;
    logic [31:0]      w_wdata;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_timeout;

    // Pick the addressed byte/half out of the bus word and extend it.
    function automatic logic [31:0] extract(input logic [2:0]  funct3,
                                            input logic [1:0]  off,
                                            input logic [31:0] data);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(data >> {off, 3'b000});
        h = 16'(data >> {off[1], 4'b0000});
        case (funct3)
            3'b000:  extract = {{24{b[7]}}, b};
            3'b100:  extract = {24'd0, b};
            3'b001:  extract = {{16{h[15]}}, h};
            3'b101:  extract = {16'd0, h};
            default: extract = data;
        endcase
    endfunction

    // Request decode: legality, alignment, lane selects and write data.
    always_comb begin
        w_illegal  = i_we ? (i_funct3 > 3'd2)
                          : (i_funct3 == 3'd3 || i_funct3 == 3'd6 || i_funct3 == 3'd7);
        w_misalign = ((i_funct3[1:0] == 2'd1) && i_addr[0]) ||
                     ((i_funct3[1:0] == 2'd2) && (i_addr[1:0] != 2'b00));
        w_sel      = 4'b1111;
        w_wdata    = i_wdata;
        case (i_funct3[1:0])
            2'd0: begin
                w_sel   = 4'b0001 << i_addr[1:0];
                w_wdata = {4{i_wdata[7:0]}};
            end
            2'd1: begin
                w_sel   = i_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                w_sel   = 4'b1111;
                w_wdata = i_wdata;
            end
        endcase
        if (!i_we) begin
            w_wdata = 32'd0;
        end
    end

    // The count compares against the cycle now ending, so the strobe stays
    // up for exactly TIMEOUT_CYCLES cycles before being dropped.
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_misalign <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= 32'd0;
            r_wb_addr  <= 32'd0;
            r_wb_cyc   <= 1'b0;
            r_wb_stb   <= 1'b0;
            r_wb_we    <= 1'b0;
            r_wb_sel   <= 4'd0;
            r_wb_wdata <= 32'd0;
            r_funct3   <= 3'd0;
            r_off      <= 2'd0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req) begin
                        r_ready <= 1'b0;
                        if (w_illegal) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_rdata <= 32'd0;
                            r_state <= S_RESP;
                        end else if (w_misalign) begin
                            r_misalign <= 1'b1;
                            r_done     <= 1'b1;
                            r_rdata    <= 32'd0;
                            r_state    <= S_RESP;
                        end else begin
                            r_wb_addr  <= {i_addr[31:2], 2'b00};
                            r_wb_we    <= i_we;
                            r_wb_sel   <= w_sel;
                            r_wb_wdata <= w_wdata;
                            r_wb_cyc   <= 1'b1;
                            r_wb_stb   <= 1'b1;
                            r_funct3   <= i_funct3;
                            r_off      <= i_addr[1:0];
                            r_cnt      <= '0;
                            r_state    <= S_BUS;
                        end
                    end
                end
                S_BUS: begin
                    // Ack takes priority over a timeout in the same cycle.
                    if (i_wb_ack) begin
                        r_wb_cyc <= 1'b0;
                        r_wb_stb <= 1'b0;
                        if (!r_wb_we) begin
                            r_rdata <= extract(r_funct3, r_off, i_wb_rdata);
                        end
                        r_done  <= 1'b1;
                        r_state <= S_RESP;
                    end else if (w_timeout) begin
                        r_wb_cyc <= 1'b0;
                        r_wb_stb <= 1'b0;
                        r_err    <= 1'b1;
                        r_rdata  <= 32'd0;
                        r_done   <= 1'b1;
                        r_state  <= S_RESP;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_RESP: begin
                    r_done     <= 1'b0;
                    r_err      <= 1'b0;
                    r_misalign <= 1'b0;
                    r_ready    <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready    = r_ready;
    assign o_done     = r_done;
    assign o_rdata    = r_rdata;
    assign o_misalign = r_misalign;
    assign o_err      = r_err;
    assign o_wb_addr  = r_wb_addr;
    assign o_wb_cyc   = r_wb_cyc;
    assign o_wb_stb   = r_wb_stb;
    assign o_wb_we    = r_wb_we;
    assign o_wb_sel   = r_wb_sel;
    assign o_wb_wdata = r_wb_wdata;

endmodule

// File: tb/tb_wb_lsu.sv
// -----------------------------------------------------------------------------
// tb_wb_lsu : self-checking bench for wb_lsu (TIMEOUT_CYCLES = 4).
// A Wishbone slave with programmable ack delay answers bus cycles; each
// transaction is compared against expectations computed from the access rules.
// -----------------------------------------------------------------------------
module tb_wb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic        i_we;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [2:0]  i_funct3;
    logic        o_ready;
    logic        o_done;
    logic [31:0] o_rdata;
    logic        o_misalign;
    logic        o_err;
    logic [31:0] o_wb_addr;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [3:0]  o_wb_sel;
    logic [31:0] o_wb_wdata;
    logic        wb_ack;
    logic [31:0] wb_rdata;

    // Slave model state
    logic        ack_en;
    int          ack_dly;
    int          stb_age;
    logic [31:0] slave_rd;

    int          n_chk = 0;
    int          n_bad = 0;
    logic [31:0] exp_rdata = 32'd0;

    always #5 clk = ~clk;

    wb_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_req      (i_req),
        .i_we       (i_we),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .i_funct3   (i_funct3),
        .o_ready    (o_ready),
        .o_done     (o_done),
        .o_rdata    (o_rdata),
        .o_misalign (o_misalign),
        .o_err      (o_err),
        .o_wb_addr  (o_wb_addr),
        .o_wb_cyc   (o_wb_cyc),
        .o_wb_stb   (o_wb_stb),
        .o_wb_we    (o_wb_we),
        .o_wb_sel   (o_wb_sel),
        .o_wb_wdata (o_wb_wdata),
        .i_wb_ack   (wb_ack),
        .i_wb_rdata (wb_rdata)
    );

    // Combinational ack once the strobe has been up for ack_dly full cycles.
    assign wb_ack   = o_wb_cyc & o_wb_stb & ack_en & (stb_age >= ack_dly);
    assign wb_rdata = wb_ack ? slave_rd : 32'h5A5A_0F0F;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) stb_age <= 0;
        else        stb_age <= (o_wb_cyc && o_wb_stb) ? stb_age + 1 : 0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Load result from the addressed lane, extended by plain arithmetic.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rd);
        longint v;
        case (f3[1:0])
            2'd0: begin
                v = longint'((rd >> (8 * addr[1:0])) & 32'hFF);
                if (f3 == 3'd0 && v >= 128) v = v - 256;
            end
            2'd1: begin
                v = longint'((rd >> (16 * addr[1])) & 32'hFFFF);
                if (f3 == 3'd1 && v >= 32768) v = v - 65536;
            end
            default: v = longint'(rd);
        endcase
        return 32'(v);
    endfunction

    // One request, issued at the current negedge; returns at the negedge of
    // the cycle after o_done (the first cycle a new request may be accepted).
    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] f3, input logic [31:0] rd, input int dly,
                        input bit ack_on, input bit noise, input string tag);
        logic        legal, mis, bus, tmo;
        logic [3:0]  esel;
        logic [31:0] ewd;
        int          estb;
        int          nstb    = 0;
        int          done_at = 0;
        logic [3:0]  gsel  = 4'd0;
        logic [31:0] gaddr = 32'd0;
        logic [31:0] gwd   = 32'd0;
        logic        gwe   = 1'b0;
        logic        gerr  = 1'b0;
        logic        gmis  = 1'b0;
        logic [31:0] grd   = 32'd0;

        legal = we ? (f3 <= 3'd2) : !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        mis   = legal && ((f3[1:0] == 2'd1 && addr[0]) ||
                          (f3[1:0] == 2'd2 && addr[1:0] != 2'b00));
        bus   = legal && !mis;
        tmo   = bus && (!ack_on || dly >= 4);
        estb  = !bus ? 0 : (tmo ? 4 : dly + 1);
        case (f3[1:0])
            2'd0: begin
                esel = 4'(1 << addr[1:0]);
                ewd  = (wd & 32'hFF) * 32'h0101_0101;
            end
            2'd1: begin
                esel = 4'(3 << (2 * addr[1]));
                ewd  = (wd & 32'hFFFF) * 32'h0001_0001;
            end
            default: begin
                esel = 4'hF;
                ewd  = wd;
            end
        endcase
        if (!we) ewd = 32'd0;
        if (!bus || tmo)  exp_rdata = 32'd0;
        else if (!we)     exp_rdata = ref_load(f3, addr, rd);

        check({tag, "_ready"}, {31'd0, o_ready}, 32'd1);
        i_req    = 1'b1;
        i_we     = we;
        i_addr   = addr;
        i_wdata  = wd;
        i_funct3 = f3;
        slave_rd = rd;
        ack_en   = ack_on;
        ack_dly  = dly;
        @(posedge clk);
        #1;
        i_req = noise;
        if (noise) begin
            i_we     = ~we;
            i_addr   = addr ^ 32'h4;
            i_funct3 = 3'd2;
        end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (o_wb_cyc && o_wb_stb) begin
                if (nstb == 0) begin
                    gsel  = o_wb_sel;
                    gaddr = o_wb_addr;
                    gwd   = o_wb_wdata;
                    gwe   = o_wb_we;
                end
                nstb++;
            end
            if (o_done) begin
                done_at = k;
                gerr    = o_err;
                gmis    = o_misalign;
                grd     = o_rdata;
                break;
            end
        end
        i_req = 1'b0;
        check({tag, "_done_cycle"}, done_at, bus ? estb + 1 : 1);
        check({tag, "_stb_cycles"}, nstb, estb);
        if (bus) begin
            check({tag, "_addr"},  gaddr, {addr[31:2], 2'b00});
            check({tag, "_sel"},   {28'd0, gsel}, {28'd0, esel});
            check({tag, "_wdata"}, gwd, ewd);
            check({tag, "_we"},    {31'd0, gwe}, {31'd0, we});
        end
        check({tag, "_err"},      {31'd0, gerr}, {31'd0, (!legal || tmo)});
        check({tag, "_misalign"}, {31'd0, gmis}, {31'd0, mis});
        check({tag, "_rdata"},    grd, exp_rdata);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, o_done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;

        rst_n    = 1'b0;
        i_req    = 1'b0;
        i_we     = 1'b0;
        i_addr   = 32'd0;
        i_wdata  = 32'd0;
        i_funct3 = 3'd0;
        ack_en   = 1'b0;
        ack_dly  = 0;
        slave_rd = 32'd0;
        #12;
        check("rst_ready", {31'd0, o_ready}, 32'd1);
        check("rst_ctl",   {26'd0, o_done, o_err, o_misalign, o_wb_cyc, o_wb_stb, o_wb_we}, 32'd0);
        check("rst_sel",   {28'd0, o_wb_sel}, 32'd0);
        check("rst_addr",  o_wb_addr, 32'd0);
        check("rst_wdata", o_wb_wdata, 32'd0);
        check("rst_rdata", o_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        xact(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3'b010, 32'h0, 0, 1'b1, 1'b0, "sw");
        xact(1'b1, 32'h0000_0013, 32'h0000_00A5, 3'b000, 32'h0, 0, 1'b1, 1'b0, "sb");
        xact(1'b0, 32'h0000_0013, 32'h0,        3'b000, 32'hA500_0000, 0, 1'b1, 1'b0, "lb");
        xact(1'b1, 32'h0000_0020, 32'h1357_9BDF, 3'b001, 32'h0, 1, 1'b1, 1'b0, "sh_keep");
        xact(1'b0, 32'h0000_0013, 32'h0,        3'b100, 32'hA500_0000, 0, 1'b1, 1'b0, "lbu");
        xact(1'b0, 32'h0000_0022, 32'h0,        3'b001, 32'h8001_1234, 0, 1'b1, 1'b0, "lh");
        xact(1'b0, 32'h0000_0022, 32'h0,        3'b101, 32'h8001_1234, 0, 1'b1, 1'b0, "lhu");
        xact(1'b0, 32'h0000_0006, 32'h0,        3'b010, 32'h1111_1111, 0, 1'b1, 1'b0, "lw_mis");
        xact(1'b1, 32'h0000_0008, 32'h0,        3'b011, 32'h0, 0, 1'b1, 1'b0, "st_ill");
        xact(1'b0, 32'h0000_0030, 32'h0,        3'b010, 32'hCAFE_F00D, 0, 1'b0, 1'b0, "lw_tmo");
        xact(1'b1, 32'h0000_0034, 32'h0BAD_CAFE, 3'b010, 32'h0, 0, 1'b1, 1'b0, "sw_after_tmo");
        xact(1'b0, 32'h0000_0031, 32'h0,        3'b000, 32'h0077_8800, 3, 1'b1, 1'b1, "lb_ack_at_limit");
        xact(1'b0, 32'h0000_0044, 32'h0,        3'b010, 32'h7654_3210, 2, 1'b1, 1'b1, "lw_busy_req");

        // Randomized traffic
        for (int t = 0; t < 150; t++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                f3 = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
                if (f3 == 3'd3) f3 = 3'd4;
            end
            addr = $urandom;
            if ($urandom_range(0, 2) != 0) begin
                if (f3[1:0] == 2'd1) addr[0] = 1'b0;
                if (f3[1:0] == 2'd2) addr[1:0] = 2'b00;
            end
            xact(we, addr, $urandom, f3, $urandom, int'($urandom_range(0, 4)),
                 ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), "rnd");
        end

        // Asynchronous reset in the middle of a bus cycle
        check("arst_ready0", {31'd0, o_ready}, 32'd1);
        i_req    = 1'b1;
        i_we     = 1'b0;
        i_addr   = 32'h0000_0040;
        i_funct3 = 3'b010;
        ack_en   = 1'b0;
        @(posedge clk);
        #1;
        i_req = 1'b0;
        @(negedge clk);
        check("arst_stb_before", {31'd0, o_wb_stb}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cyc_stb", {30'd0, o_wb_cyc, o_wb_stb}, 32'd0);
        check("arst_done",    {31'd0, o_done}, 32'd0);
        check("arst_ready",   {31'd0, o_ready}, 32'd1);
        check("arst_rdata",   o_rdata, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        exp_rdata = 32'd0;
        xact(1'b0, 32'h0000_0040, 32'h0, 3'b010, 32'h1234_5678, 1, 1'b1, 1'b0, "lw_after_rst");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
